mux_scanner: RTL and testbench



---
 rtl/mux_pkg.sv | 22 ++
 rtl/settle_timer.sv | 29 ++
 rtl/mux_scanner.sv | 103 ++++++++++
 tb/tb_mux_scanner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the 4:1 mux scanner.
package mux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Index of the last channel in a scan.
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  // Advance to the following mux channel.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return s + SEL_W'(1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Counts the settle window after a select change; done_c marks its last cycle.
module settle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign done_c = en_i && (cnt_q == CNT_W'(CYCLES - 1));

  // Count up while enabled, wrap to zero on the final settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= done_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scanner.sv
// Sequences a 4:1 mux through all channels, captures each output bit after a
// settle window and hands the assembled word downstream over valid/ready.
module mux_scanner
  import mux_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          CONTINUOUS    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mux_out,
  input  logic              ready,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] sample,
  output logic              valid,
  output logic              busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("mux_scanner: SETTLE_CYCLES must be within 1..255");
  end

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_CH-1:0] sample_q;
  logic              valid_q;
  logic              busy_q;
  logic              settle_done_c;

  // Timer only runs in SETTLE and sits at zero everywhere else.
  settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q != ST_SETTLE),
    .en_i    (state_q == ST_SETTLE),
    .done_c  (settle_done_c)
  );

  // Scan sequencer: select stepping, per-channel capture and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q    <= '0;
            sample_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_done_c) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          sample_q[sel_q] <= mux_out;
          if (sel_q == LAST_SEL) begin
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            sel_q   <= next_sel(sel_q);
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // start is deliberately ignored here; only the handshake counts.
          if (ready) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            if (CONTINUOUS) begin
              sample_q <= '0;
              state_q  <= ST_SETTLE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = sel_q;
  assign sample = sample_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner with a scoreboard of expected scan words.
module tb_mux_scanner;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ready;
  logic [3:0] din;
  logic       mux_o;
  logic [1:0] sel;
  logic [3:0] sample;
  logic       valid;
  logic       busy;

  logic       start2;
  logic [3:0] din2;
  logic       mux_o2;
  logic [1:0] sel2;
  logic [3:0] sample2;
  logic       valid2;
  logic       busy2;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] sb_q[$];
  logic [3:0] sb_q2[$];

  // 4:1 single-bit multiplexers in front of each scanner.
  assign mux_o  = din[sel];
  assign mux_o2 = din2[sel2];

  mux_scanner u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mux_out (mux_o),
    .ready   (ready),
    .sel     (sel),
    .sample  (sample),
    .valid   (valid),
    .busy    (busy)
  );

  mux_scanner #(
    .SETTLE_CYCLES (1),
    .CONTINUOUS    (1'b1)
  ) u_cont (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .mux_out (mux_o2),
    .ready   (1'b1),
    .sel     (sel2),
    .sample  (sample2),
    .valid   (valid2),
    .busy    (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the start edge.
  task automatic start_scan(input logic [3:0] w);
    din   = w;
    start = 1'b1;
    sb_q.push_back(w);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step negedges until valid, check latency, then compare against scoreboard.
  task automatic wait_valid(input int j0, input int exp_lat);
    int j;
    j = j0;
    while (valid !== 1'b1 && j < 100) begin
      @(negedge clk);
      j++;
    end
    chk("latency", 32'(j), 32'(exp_lat));
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) chk("sample", 32'(sample), 32'(sb_q.pop_front()));
  endtask

  initial begin
    logic [3:0] exp_part;
    rst    = 1'b1;
    start  = 1'b0;
    ready  = 1'b0;
    din    = 4'b0000;
    start2 = 1'b0;
    din2   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset with no start.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 32'({sel, sample, valid, busy}), 32'd0);
    end

    // Basic scan with exact select stepping and partial-word checks.
    din   = 4'b1101;
    start = 1'b1;
    sb_q.push_back(4'b1101);
    @(negedge clk);
    start = 1'b0;
    chk("scan_j0", 32'({sel, valid, busy}), 32'({2'd0, 1'b0, 1'b1}));
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      exp_part = 4'b0000;
      for (int c = 0; c < 4; c++) if (j >= 3 * (c + 1)) exp_part[c] = din[c];
      chk("scan_sel", 32'(sel), (j < 12) ? 32'(j / 3) : 32'd3);
      chk("scan_valid", 32'(valid), 32'(j == 12));
      if (j < 12) chk("scan_partial", 32'(sample), 32'(exp_part));
    end
    chk("scan_word", 32'(sample), 32'(sb_q.pop_front()));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("hs_idle", 32'({sel, valid, busy}), 32'd0);
    chk("hs_retain", 32'(sample), 32'h0000_000d);

    // Backpressure: hold 10 cycles with a start pulse and input churn.
    start_scan(4'b0110);
    wait_valid(0, 12);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'({sel, sample, valid, busy}), 32'({2'd3, 4'b0110, 1'b1, 1'b1}));
      start = (i == 3);
      din   = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("bp_release", 32'({sel, sample, valid, busy}), 32'({2'd0, 4'b0110, 1'b0, 1'b0}));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("bp_noqueue", 32'({valid, busy}), 32'd0);
    end

    // Glitches on I1 during its settle window; I1 is 0 in the capture cycle.
    ready = 1'b1;
    din   = 4'b1011;
    start = 1'b1;
    sb_q.push_back(4'b1001);
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      din[1] = (j == 5) ? 1'b0 : ~din[1];
    end
    wait_valid(5, 12);
    @(negedge clk);
    chk("glitch_done", 32'({sel, sample, valid, busy}), 32'({2'd0, 4'b1001, 1'b0, 1'b0}));
    ready = 1'b0;

    // Continuous mode, SETTLE_CYCLES=1, ready tied high.
    din2   = 4'b1010;
    start2 = 1'b1;
    for (int i = 0; i < 4; i++) sb_q2.push_back(4'b1010);
    @(negedge clk);
    start2 = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      chk("cont_valid", 32'(valid2), 32'((j >= 8) && ((j - 8) % 9 == 0)));
      chk("cont_busy", 32'(busy2), 32'd1);
      if (valid2 === 1'b1) begin
        chk("cont_sb_nonempty", 32'(sb_q2.size() != 0), 32'd1);
        if (sb_q2.size() != 0) chk("cont_word", 32'(sample2), 32'(sb_q2.pop_front()));
      end
    end
    chk("cont_sb_empty", 32'(sb_q2.size()), 32'd0);

    // Asynchronous reset while channel 2 is selected.
    din   = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 7; j++) @(negedge clk);
    chk("mid_sel", 32'(sel), 32'd2);
    chk("mid_partial", 32'(sample), 32'h0000_0003);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({sel, sample, valid, busy}), 32'd0);
    chk("async_rst_cont", 32'({sel2, sample2, valid2, busy2}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'({sel, sample, valid, busy}), 32'd0);
    start_scan(4'b0101);
    wait_valid(0, 12);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("post_rst_hs", 32'({sel, sample, valid, busy}), 32'({2'd0, 4'b0101, 1'b0, 1'b0}));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
